sec_timer: RTL and testbench

//  Seconds timer that produces the 6-bit secs value consumed by the seven-segment decoder stage.

---
 rtl/sec_timer_pkg.sv | 22 ++
 rtl/sec_timer_tick_prescaler.sv | 31 +++
 rtl/sec_timer.sv | 127 ++++++++++++
 tb/tb_sec_timer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sec_timer_pkg.sv
// Shared types for the seconds timer: FSM states, count
// direction constants and the preset saturation helper.
package sec_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  function automatic logic [5:0] sat_secs(
    input logic [5:0] v,
    input logic [5:0] max
  );
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/sec_timer_tick_prescaler.sv
// Divides clk by DIV; tick pulses on the last count while en.
// Ports: clk, rst (sync, high), en (count), clr (zero) -> tick.
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Holding while en is low keeps the fractional second
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sec_timer.sv
// Seconds stopwatch/countdown with start/pause/clear/load buttons.
// Ports: clk, rst, start, pause, clear, load, load_val, dir -> secs, running, expired, alarm.
module sec_timer
  import sec_timer_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 1,
  parameter int MAX_SECS = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       load,
  input  logic [5:0] load_val,
  input  logic       dir,
  output logic [5:0] secs,
  output logic       running,
  output logic       expired,
  output logic       alarm
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam logic [5:0] MAXV = 6'(MAX_SECS);

  state_t     state, state_d;
  logic [5:0] secs_d;
  logic       exp_d;
  logic       pre_clr;
  logic       tick;

  logic start_q, pause_q, clear_q, load_q;
  logic start_re, pause_re, clear_re, load_re;

  assign start_re = start & ~start_q;
  assign pause_re = pause & ~pause_q;
  assign clear_re = clear & ~clear_q;
  assign load_re  = load  & ~load_q;

  // History resets high so a button held through reset is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b1;
      pause_q <= 1'b1;
      clear_q <= 1'b1;
      load_q  <= 1'b1;
    end else begin
      start_q <= start;
      pause_q <= pause;
      clear_q <= clear;
      load_q  <= load;
    end
  end

  tick_prescaler #(
    .DIV(DIV)
  ) u_pre (
    .clk (clk),
    .rst (rst),
    .en  (state == ST_RUN),
    .clr (pre_clr),
    .tick(tick)
  );

  always_comb begin
    state_d = state;
    secs_d  = secs;
    exp_d   = 1'b0;
    pre_clr = 1'b0;
    if (clear_re) begin
      state_d = ST_IDLE;
      secs_d  = '0;
      pre_clr = 1'b1;
    end else if (load_re) begin
      state_d = ST_IDLE;
      secs_d  = sat_secs(load_val, MAXV);
      pre_clr = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_re && !(dir == DIR_DN && secs == '0)) begin
            state_d = ST_RUN;
            pre_clr = 1'b1;
          end
        end
        ST_RUN: begin
          if (pause_re) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            if (dir == DIR_UP) begin
              secs_d = (secs == MAXV) ? '0 : secs + 1'b1;
            end else if (secs <= 6'd1) begin
              // Covers 1->0 and a dir flip while already at 0
              secs_d  = '0;
              state_d = ST_DONE;
              exp_d   = 1'b1;
            end else begin
              secs_d = secs - 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (start_re) state_d = ST_RUN;
        end
        ST_DONE: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      secs    <= '0;
      expired <= 1'b0;
    end else begin
      state   <= state_d;
      secs    <= secs_d;
      expired <= exp_d;
    end
  end

  assign running = (state == ST_RUN);
  assign alarm   = (state == ST_DONE);

endmodule

// File: tb/tb_sec_timer.sv
// Randomized and directed bench for sec_timer against a
// behavioural seconds-timer model.
module tb_sec_timer;

  localparam int DIV  = 10;
  localparam int MAXS = 59;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  localparam int B_START = 0;
  localparam int B_PAUSE = 1;
  localparam int B_CLEAR = 2;
  localparam int B_LOAD  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, pause, clear, load, dir;
  logic [5:0] load_val;
  logic [5:0] secs;
  logic       running, expired, alarm;

  int errors = 0;
  int checks = 0;

  int m_mode, m_secs, m_frac;
  bit m_exp;
  bit p_start, p_pause, p_clear, p_load;

  always #5 clk = ~clk;

  sec_timer #(
    .CLK_HZ  (10),
    .TICK_HZ (1),
    .MAX_SECS(MAXS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pause   (pause),
    .clear   (clear),
    .load    (load),
    .load_val(load_val),
    .dir     (dir),
    .secs    (secs),
    .running (running),
    .expired (expired),
    .alarm   (alarm)
  );

  // One clock of the reference timer, using the inputs seen at the edge
  task automatic model_edge();
    bit s, p, c, l, tk;
    if (rst) begin
      m_mode = M_IDLE; m_secs = 0; m_frac = 0; m_exp = 0;
      p_start = 1; p_pause = 1; p_clear = 1; p_load = 1;
      return;
    end
    s = start && !p_start;
    p = pause && !p_pause;
    c = clear && !p_clear;
    l = load && !p_load;
    p_start = start; p_pause = pause;
    p_clear = clear; p_load = load;
    m_exp = 0;
    tk = (m_mode == M_RUN) && (m_frac == DIV - 1);
    if (m_mode == M_RUN) m_frac = (m_frac + 1) % DIV;
    if (c) begin
      m_mode = M_IDLE; m_secs = 0; m_frac = 0;
    end else if (l) begin
      m_mode = M_IDLE; m_frac = 0;
      m_secs = (int'(load_val) > MAXS) ? MAXS : int'(load_val);
    end else if (m_mode == M_IDLE) begin
      if (s && !(dir && m_secs == 0)) begin
        m_mode = M_RUN; m_frac = 0;
      end
    end else if (m_mode == M_RUN) begin
      if (p) m_mode = M_PAUSE;
      else if (tk) begin
        if (!dir) m_secs = (m_secs + 1) % (MAXS + 1);
        else if (m_secs <= 1) begin
          m_secs = 0; m_mode = M_DONE; m_exp = 1;
        end else m_secs = m_secs - 1;
      end
    end else if (m_mode == M_PAUSE) begin
      if (s) m_mode = M_RUN;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic press(input int b);
    case (b)
      B_START: start = 1'b1;
      B_PAUSE: pause = 1'b1;
      B_CLEAR: clear = 1'b1;
      default: load  = 1'b1;
    endcase
    step();
    start = 1'b0; pause = 1'b0; clear = 1'b0; load = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; pause = 0; clear = 0; load = 0;
    dir = 0; load_val = '0;
    step(); step();
    checks++;
    if ({secs, running, expired, alarm} !== 9'h0) begin
      errors++;
      $display("FAIL reset got=%h want=000", {secs, running, expired, alarm});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_countdown();
    int npulse = 0, gap = 0;
    load_val = 6'd5;
    press(B_LOAD);
    dir = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (running !== 1'b1 || secs !== 6'd5) begin
      errors++;
      $display("FAIL cd_start run=%b secs=%0d want 1/5", running, secs);
    end
    for (int i = 0; i < 60; i++) begin
      logic [5:0] prev = secs;
      step();
      gap++;
      checks++;
      if ({secs, running, expired, alarm} !==
          {6'(m_secs), m_mode == M_RUN, m_exp, m_mode == M_DONE}) begin
        errors++;
        $display("FAIL cd_model t=%0t got=%h want=%h", $time,
                 {secs, running, expired, alarm},
                 {6'(m_secs), m_mode == M_RUN, m_exp, m_mode == M_DONE});
      end
      if (secs !== prev) begin
        checks++;
        if (gap != DIV || secs !== prev - 6'd1) begin
          errors++;
          $display("FAIL cd_tick gap=%0d secs=%0d want gap=10 secs=%0d",
                   gap, secs, prev - 6'd1);
        end
        gap = 0;
      end
      if (expired === 1'b1) begin
        npulse++;
        checks++;
        if (secs !== 6'd0) begin
          errors++;
          $display("FAIL cd_exp_secs got=%0d want=0", secs);
        end
      end
    end
    checks++;
    if (npulse != 1 || alarm !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL cd_done pulses=%0d alarm=%b run=%b want 1/1/0",
               npulse, alarm, running);
    end
  endtask

  task automatic test_wrap();
    int wraps = 0;
    dir = 1'b0;
    press(B_CLEAR);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 605; i++) begin
      logic [5:0] prev = secs;
      step();
      if (prev == 6'd59 && secs == 6'd0) wraps++;
      checks++;
      if (secs !== 6'(m_secs) || secs > 6'd59 || running !== 1'b1) begin
        errors++;
        $display("FAIL wrap t=%0t secs=%0d run=%b want secs=%0d run=1",
                 $time, secs, running, m_secs);
      end
    end
    checks++;
    if (wraps != 1 || secs !== 6'd0) begin
      errors++;
      $display("FAIL wrap_count wraps=%0d secs=%0d want 1/0", wraps, secs);
    end
  endtask

  task automatic test_pause();
    int k = 0;
    dir = 1'b0;
    press(B_CLEAR);
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    pause = 1'b1; step(); pause = 1'b0;
    for (int i = 0; i < 49; i++) begin
      step();
      checks++;
      if (secs !== 6'd0 || running !== 1'b0 || m_mode != M_PAUSE) begin
        errors++;
        $display("FAIL pause_hold secs=%0d run=%b want 0/0", secs, running);
      end
    end
    start = 1'b1; step(); start = 1'b0;
    while (secs == 6'd0 && k < 20) begin
      step();
      k++;
    end
    checks++;
    if (k != 6 || secs !== 6'd1 || secs !== 6'(m_secs)) begin
      errors++;
      $display("FAIL pause_resume clks=%0d secs=%0d want 6/1", k, secs);
    end
  endtask

  task automatic test_load_sat();
    load_val = 6'd63;
    press(B_LOAD);
    checks++;
    if (secs !== 6'd59 || running !== 1'b0) begin
      errors++;
      $display("FAIL load_sat secs=%0d want=59", secs);
    end
    press(B_CLEAR);
    dir = 1'b1;
    press(B_START);
    checks++;
    if (running !== 1'b0 || secs !== 6'd0 || m_mode != M_IDLE) begin
      errors++;
      $display("FAIL dn_zero_start run=%b secs=%0d want 0/0", running, secs);
    end
  endtask

  task automatic test_same_cycle();
    dir = 1'b0;
    press(B_CLEAR);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    clear = 1'b1; start = 1'b1;
    step();
    clear = 1'b0; start = 1'b0;
    checks++;
    if (secs !== 6'd0 || running !== 1'b0 || m_secs != 0) begin
      errors++;
      $display("FAIL same_cycle secs=%0d run=%b want 0/0", secs, running);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (secs !== 6'(m_secs) || running !== 1'b0) begin
        errors++;
        $display("FAIL same_cycle_idle secs=%0d run=%b want 0/0",
                 secs, running);
      end
    end
  endtask

  task automatic test_done_reset();
    int n = 0;
    load_val = 6'd1;
    press(B_LOAD);
    dir = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 12; i++) step();
    press(B_START);
    press(B_PAUSE);
    checks++;
    if (alarm !== 1'b1 || running !== 1'b0 || secs !== 6'd0) begin
      errors++;
      $display("FAIL done_ignore alarm=%b run=%b secs=%0d want 1/0/0",
               alarm, running, secs);
    end
    dir = 1'b0;
    start = 1'b1; rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step(); step(); step();
    checks++;
    if (running !== 1'b0 || alarm !== 1'b0 || m_mode != M_IDLE) begin
      errors++;
      $display("FAIL held_start run=%b alarm=%b want 0/0", running, alarm);
    end
    start = 1'b0;
    step();
    press(B_CLEAR);
    start = 1'b1; step(); start = 1'b0;
    while (secs != 6'd7 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (secs !== 6'd7 || running !== 1'b1) begin
      errors++;
      $display("FAIL reach7 secs=%0d run=%b want 7/1", secs, running);
    end
    rst = 1'b1;
    step();
    checks++;
    if (secs !== 6'd0 || running !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst secs=%0d run=%b want 0/0", secs, running);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) start = ~start;
      if ($urandom_range(0, 23) == 0) pause = ~pause;
      if ($urandom_range(0, 63) == 0) clear = ~clear;
      if ($urandom_range(0, 47) == 0) load  = ~load;
      if ($urandom_range(0, 63) == 0) dir   = ~dir;
      load_val = 6'($urandom_range(0, 63));
      rst = ($urandom_range(0, 299) == 0);
      step();
      checks++;
      if ({secs, running, expired, alarm} !==
          {6'(m_secs), m_mode == M_RUN, m_exp, m_mode == M_DONE}) begin
        errors++;
        $display("FAIL random t=%0t got=%h want=%h", $time,
                 {secs, running, expired, alarm},
                 {6'(m_secs), m_mode == M_RUN, m_exp, m_mode == M_DONE});
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_wrap();
    test_pause();
    test_load_sat();
    test_same_cycle();
    test_done_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
